var_mux_seq: RTL

Parametrised successor to the fixed 8-bit 3-to-1 variable selector in the SPI path. It selects one of CHANNELS packed WIDTH-bit input words into a registered output with valid/ready handshake. It supports two modes: direct (one word per load, channel chosen by sel) and scan (one load emits every mask-enabled channel in ascending order as a frame). It sits between the variable sources and the SPI transmit shifter, which consumes words via out_ready.

---
 rtl/var_mux_seq_if.sv | 31 +++
 rtl/var_mux_seq.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/var_mux_seq_if.sv
// Handshake/bus bundle between the variable sources, the selector and the SPI shifter.
interface var_mux_seq_if #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CHANNELS = 3,
  parameter int unsigned SEL_W    = 2
);
  logic [CHANNELS*WIDTH-1:0] in_bus;
  logic                      mode;
  logic [SEL_W-1:0]          sel;
  logic [CHANNELS-1:0]       ch_mask;
  logic                      load;
  logic [WIDTH-1:0]          out;
  logic [SEL_W-1:0]          out_ch;
  logic                      out_valid;
  logic                      out_ready;
  logic                      frame_end;
  logic                      busy;
  logic                      sel_err;

  // Request side / consumer side (testbench or upstream logic)
  modport master (
    output in_bus, mode, sel, ch_mask, load, out_ready,
    input  out, out_ch, out_valid, frame_end, busy, sel_err
  );

  // Selector side
  modport slave (
    input  in_bus, mode, sel, ch_mask, load, out_ready,
    output out, out_ch, out_valid, frame_end, busy, sel_err
  );
endinterface

// File: rtl/var_mux_seq.sv
// Variable selector: direct single-word loads or masked ascending scan frames,
// presented through a registered valid/ready output slot.
module var_mux_seq #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CHANNELS = 3,
  parameter int unsigned SEL_W    = 2
) (
  input logic          clk,
  input logic          rst,
  var_mux_seq_if.slave bus
);
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SCAN = 1'b1;

  logic [0:0]          state_q, state_d;
  logic [SEL_W-1:0]    ptr_q, ptr_d;
  logic [CHANNELS-1:0] mask_r_q, mask_r_d;
  logic [WIDTH-1:0]    out_q, out_d;
  logic [SEL_W-1:0]    out_ch_q, out_ch_d;
  logic                out_valid_q, out_valid_d;
  logic                frame_end_q, frame_end_d;
  logic                busy_q, busy_d;
  logic                sel_err_q, sel_err_d;

  logic                slot_free;
  logic                sel_ok;
  logic                has_next;
  logic [SEL_W-1:0]    first_idx, next_idx;
  logic [WIDTH-1:0]    sel_word, ptr_word;

  assign slot_free = !out_valid_q || bus.out_ready;
  assign sel_ok    = 32'(bus.sel) < CHANNELS;

  // Channel word muxes for the direct index and the scan pointer
  always_comb begin
    sel_word = '0;
    ptr_word = '0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      if (bus.sel == SEL_W'(k)) sel_word = bus.in_bus[k*WIDTH +: WIDTH];
      if (ptr_q == SEL_W'(k))   ptr_word = bus.in_bus[k*WIDTH +: WIDTH];
    end
  end

  // Priority search: lowest bit of the new mask, next set bit above ptr in the frame mask
  always_comb begin
    first_idx = '0;
    next_idx  = '0;
    has_next  = 1'b0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (bus.ch_mask[CHANNELS-1-i]) first_idx = SEL_W'(CHANNELS-1-i);
      if (mask_r_q[CHANNELS-1-i] && (SEL_W'(CHANNELS-1-i) > ptr_q)) begin
        next_idx = SEL_W'(CHANNELS-1-i);
        has_next = 1'b1;
      end
    end
  end

  // Next-state and output-slot logic
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    mask_r_d    = mask_r_q;
    out_d       = out_q;
    out_ch_d    = out_ch_q;
    out_valid_d = out_valid_q;
    frame_end_d = frame_end_q;
    busy_d      = busy_q;
    sel_err_d   = 1'b0;

    // A free slot drains unless something is captured below
    if (slot_free) begin
      out_valid_d = 1'b0;
      frame_end_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (bus.load) begin
          if (!bus.mode) begin
            if (!sel_ok) begin
              sel_err_d = 1'b1;
            end else if (slot_free) begin
              out_d       = sel_word;
              out_ch_d    = bus.sel;
              out_valid_d = 1'b1;
              frame_end_d = 1'b0;
            end
          end else begin
            mask_r_d = bus.ch_mask;
            if (bus.ch_mask == '0) begin
              sel_err_d = 1'b1;
            end else begin
              ptr_d   = first_idx;
              busy_d  = 1'b1;
              state_d = ST_SCAN;
            end
          end
        end
      end
      ST_SCAN: begin
        if (slot_free) begin
          out_d       = ptr_word;
          out_ch_d    = ptr_q;
          out_valid_d = 1'b1;
          if (!has_next) begin
            frame_end_d = 1'b1;
            busy_d      = 1'b0;
            state_d     = ST_IDLE;
          end else begin
            frame_end_d = 1'b0;
            ptr_d       = next_idx;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers, synchronous reset aborts any frame
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      mask_r_q    <= '0;
      out_q       <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
      frame_end_q <= 1'b0;
      busy_q      <= 1'b0;
      sel_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      mask_r_q    <= mask_r_d;
      out_q       <= out_d;
      out_ch_q    <= out_ch_d;
      out_valid_q <= out_valid_d;
      frame_end_q <= frame_end_d;
      busy_q      <= busy_d;
      sel_err_q   <= sel_err_d;
    end
  end

  assign bus.out       = out_q;
  assign bus.out_ch    = out_ch_q;
  assign bus.out_valid = out_valid_q;
  assign bus.frame_end = frame_end_q;
  assign bus.busy      = busy_q;
  assign bus.sel_err   = sel_err_q;
endmodule
